stage_writeback: RTL

- Consumes the registered control_store / control_rd_out / control_jump_target_addr words produced by the compute stage and retires them.
- Performs the data-memory store through a req/ready handshake, then commits the register-file write and the PC redirect in a single commit cycle.
- Sits between the compute stage and the register file, data memory and fetch PC logic.
- Drives is_complete so the pipeline controller can advance.

---
 rtl/stage_writeback.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/stage_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : stage_writeback
//  Brief    : Retires compute-stage results: data-memory store via req/ready,
//             then a single commit cycle for the register write and PC redirect.
//  Revision : 1.0
// ============================================================================

package stage_writeback_pkg;
    localparam int unsigned XLEN_DEFAULT = 32;

    typedef struct packed {
        logic                    enable;
        logic [XLEN_DEFAULT-1:0] value;
    } enableable_word_t;
endpackage

module stage_writeback
    import stage_writeback_pkg::*;
#(
    parameter int unsigned XLEN          = XLEN_DEFAULT,
    parameter int unsigned STORE_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  enableable_word_t control_store,
    input  enableable_word_t control_rd_out,
    input  enableable_word_t control_jump_target_addr,
    input  logic [XLEN-1:0]  store_addr,
    input  logic [1:0]       store_size,
    input  logic [4:0]       rd_index,
    output logic             dmem_req,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             pc_redirect_valid,
    output logic [XLEN-1:0]  pc_redirect_addr,
    output logic             busy,
    output logic             is_complete,
    output logic             store_error
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STORE  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    localparam int unsigned CNT_W = $clog2(STORE_TIMEOUT + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;

    logic             r_rd_we;
    logic             r_jump_en;
    logic [4:0]       r_rd_index;
    logic [XLEN-1:0]  r_rd_value;
    logic [XLEN-1:0]  r_jump_addr;
    logic [XLEN-1:0]  r_dmem_addr;
    logic [XLEN-1:0]  r_dmem_wdata;
    logic [3:0]       r_dmem_wstrb;

    logic             r_dmem_req;
    logic             r_rf_we;
    logic             r_redirect;
    logic             r_complete;
    logic             r_store_error;
    logic             r_busy;

    logic             w_accept;
    logic             w_store_illegal;
    logic             w_timeout;
    logic [XLEN-1:0]  w_wdata;
    logic [3:0]       w_wstrb;
    logic             w_dmem_req_d;
    logic             w_rf_we_d;
    logic             w_redirect_d;
    logic             w_complete_d;
    logic             w_store_error_d;
    logic             w_busy_d;

    assign w_accept  = (r_state == c_ST_IDLE) && enable;
    assign w_timeout = (r_state == c_ST_STORE) && !dmem_ready
                       && (r_cnt == CNT_W'(STORE_TIMEOUT - 1));

    assign w_store_illegal = (store_size == 2'b11)
                          || ((store_size == 2'b01) && store_addr[0])
                          || ((store_size == 2'b10) && (store_addr[1:0] != 2'b00));

    // Lane replication so the memory can pick any byte/half lane via wstrb
    always_comb begin
        w_wdata = '0;
        w_wstrb = 4'b0000;
        case (store_size)
            2'b00: begin
                w_wdata = {(XLEN/8){control_store.value[7:0]}};
                w_wstrb = 4'b0001 << store_addr[1:0];
            end
            2'b01: begin
                w_wdata = {(XLEN/16){control_store.value[15:0]}};
                w_wstrb = store_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_wdata = control_store.value;
                w_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (enable) begin
                    if (control_store.enable && !w_store_illegal) begin
                        w_state_next = c_ST_STORE;
                    end else begin
                        w_state_next = c_ST_COMMIT;
                    end
                end
            end
            c_ST_STORE: begin
                if (dmem_ready || w_timeout) begin
                    w_state_next = c_ST_COMMIT;
                end
            end
            c_ST_COMMIT: w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // Next values of the registered strobes; a direct IDLE->COMMIT hop has to
    // look at the live inputs because the capture registers load on the same edge.
    always_comb begin
        w_dmem_req_d    = (w_state_next == c_ST_STORE);
        w_complete_d    = (w_state_next == c_ST_COMMIT);
        w_busy_d        = (w_state_next != c_ST_IDLE);
        w_rf_we_d       = 1'b0;
        w_redirect_d    = 1'b0;
        w_store_error_d = 1'b0;
        if (w_state_next == c_ST_COMMIT) begin
            if (r_state == c_ST_IDLE) begin
                w_rf_we_d       = control_rd_out.enable && (rd_index != 5'd0);
                w_redirect_d    = control_jump_target_addr.enable;
                w_store_error_d = control_store.enable && w_store_illegal;
            end else begin
                w_rf_we_d       = r_rd_we;
                w_redirect_d    = r_jump_en;
                w_store_error_d = w_timeout;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dmem_req    <= 1'b0;
            r_rf_we       <= 1'b0;
            r_redirect    <= 1'b0;
            r_complete    <= 1'b0;
            r_store_error <= 1'b0;
            r_busy        <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_dmem_req    <= w_dmem_req_d;
            r_rf_we       <= w_rf_we_d;
            r_redirect    <= w_redirect_d;
            r_complete    <= w_complete_d;
            r_store_error <= w_store_error_d;
            r_busy        <= w_busy_d;
            if ((r_state == c_ST_STORE) && !dmem_ready && !w_timeout) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_we      <= 1'b0;
            r_jump_en    <= 1'b0;
            r_rd_index   <= 5'd0;
            r_rd_value   <= '0;
            r_jump_addr  <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_wstrb <= 4'b0000;
        end else if (w_accept) begin
            r_rd_we      <= control_rd_out.enable && (rd_index != 5'd0);
            r_jump_en    <= control_jump_target_addr.enable;
            r_rd_index   <= rd_index;
            r_rd_value   <= control_rd_out.value;
            r_jump_addr  <= control_jump_target_addr.value;
            r_dmem_addr  <= {store_addr[XLEN-1:2], 2'b00};
            r_dmem_wdata <= w_wdata;
            r_dmem_wstrb <= w_wstrb;
        end
    end

    assign dmem_req          = r_dmem_req;
    assign dmem_addr         = r_dmem_addr;
    assign dmem_wdata        = r_dmem_wdata;
    assign dmem_wstrb        = r_dmem_wstrb;
    assign rf_we             = r_rf_we;
    assign rf_waddr          = r_rd_index;
    assign rf_wdata          = r_rd_value;
    assign pc_redirect_valid = r_redirect;
    assign pc_redirect_addr  = r_jump_addr;
    assign busy              = r_busy;
    assign is_complete       = r_complete;
    assign store_error       = r_store_error;

endmodule

`default_nettype wire
